// File: rtl/chan_tx_arbiter.sv
// chan_tx_arbiter: frame-granular round-robin arbiter that shares one TX
// AXI4-stream path into the channel-link transmit FIFO between N_REQ sources.
// A granted requester owns the link until its tlast beat is accepted, and
// new grants are only issued while the link is up.
// Optional build macro CHAN_TX_ARB_PRIO0_EN: requester 0 gets strict priority
// over the round-robin group (rr_ptr is left alone when requester 0 wins).
module chan_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_aresetn,
  input  logic                      link_up,
  input  logic [N_REQ*DATA_W-1:0]   req_tdata,
  input  logic [N_REQ*KEEP_W-1:0]   req_tkeep,
  input  logic [N_REQ-1:0]          req_tvalid,
  input  logic [N_REQ-1:0]          req_tlast,
  output logic [N_REQ-1:0]          req_tready,
  output logic [DATA_W-1:0]         m_axis_tx_tdata,
  output logic [KEEP_W-1:0]         m_axis_tx_tkeep,
  output logic                      m_axis_tx_tvalid,
  output logic                      m_axis_tx_tlast,
  input  logic                      m_axis_tx_tready,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic [31:0]               pkt_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [N_REQ-1:0] ONE_HOT_BASE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [31:0]        pkt_count_q, pkt_count_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               found_s;
  logic [PTR_W-1:0]   winner_s;
  logic [SUM_W-1:0]   sum_s;
  logic [PTR_W-1:0]   idx_s;
  logic               prio0_win_s;
  logic               last_xfer_s;

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_count_q;

  // Round-robin search: first valid requester scanning upward from rr_ptr+1, wrapping modulo N_REQ.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    sum_s    = '0;
    idx_s    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum_s = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (sum_s >= SUM_W'(N_REQ)) begin
        sum_s = sum_s - SUM_W'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (!found_s && req_tvalid[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Strict-priority override for requester 0 when the option is built in.
  always_comb begin
`ifdef CHAN_TX_ARB_PRIO0_EN
    prio0_win_s = req_tvalid[0];
`else
    prio0_win_s = 1'b0;
`endif
  end

  // Unregistered pass-through of the granted requester onto the TX FIFO port.
  always_comb begin
    m_axis_tx_tdata  = '0;
    m_axis_tx_tkeep  = '0;
    m_axis_tx_tvalid = 1'b0;
    m_axis_tx_tlast  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        m_axis_tx_tdata  = req_tdata[i*DATA_W +: DATA_W];
        m_axis_tx_tkeep  = req_tkeep[i*KEEP_W +: KEEP_W];
        m_axis_tx_tvalid = req_tvalid[i];
        m_axis_tx_tlast  = req_tlast[i];
      end else begin
        m_axis_tx_tvalid = m_axis_tx_tvalid;
      end
    end
    req_tready  = grant_q & {N_REQ{m_axis_tx_tready}};
    last_xfer_s = m_axis_tx_tvalid & m_axis_tx_tready & m_axis_tx_tlast;
  end

  // Next-state logic: grant on the IDLE cycle, release on the accepted tlast beat.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    pkt_count_d = pkt_count_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (link_up && found_s) begin
          state_d = ST_GRANT;
          busy_d  = 1'b1;
          if (prio0_win_s) begin
            grant_d  = ONE_HOT_BASE;
            rr_ptr_d = rr_ptr_q;
          end else begin
            grant_d  = ONE_HOT_BASE << winner_s;
            rr_ptr_d = winner_s;
          end
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (last_xfer_s) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          busy_d      = 1'b0;
          pkt_count_d = pkt_count_q + 32'd1;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset (abandons any frame).
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      pkt_count_q <= 32'd0;
      rr_ptr_q    <= PTR_W'(N_REQ - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      pkt_count_q <= pkt_count_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule
